// File: rtl/vera_bus_sequencer_if.sv
// VERA external bus bundle (6502-style write-only register port).
//   cs_n  : chip select, active low
//   rd_n  : read strobe, active low
//   wr_n  : write strobe, active low
//   a     : register address
//   d_out : write data toward VERA
//   d_oe  : data bus output enable
// master drives the bus (sequencer), slave observes it (VERA side).
interface vera_bus_sequencer_if;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic [4:0] a;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (output cs_n, rd_n, wr_n, a, d_out, d_oe);
  modport slave  (input  cs_n, rd_n, wr_n, a, d_out, d_oe);
endinterface

// File: rtl/vera_bus_sequencer.sv
// Scripted bus master for VERA. Fetches 16-bit commands from a registered
// ROM and turns them into timed register writes, VBlank waits and delays.
//   clk      : system clock
//   reset    : asynchronous active-high reset
//   start    : pulse, runs the script from address 0 (only in idle/finished)
//   rom_addr : command ROM address
//   rom_data : command word, valid one clock after rom_addr changes
//   vblank   : VERA VBlank, same clock domain
//   extbus   : VERA bus (cs_n/rd_n/wr_n/a/d_out/d_oe)
//   busy     : script executing
//   done     : script reached END (sticky until next start)
//   error    : illegal op or ran off the end of the ROM (sticky)
// Command word: op=[15:13], reg=[12:8], arg=[7:0].
module vera_bus_sequencer #(
  parameter int ROM_AW     = 10,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [15:0]         rom_data,
  input  logic                vblank,
  vera_bus_sequencer_if.master extbus,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_SETUP  = 4'd3;
  localparam logic [3:0] S_STROBE = 4'd4;
  localparam logic [3:0] S_HOLD   = 4'd5;
  localparam logic [3:0] S_WAITVB = 4'd6;
  localparam logic [3:0] S_DELAY  = 4'd7;
  localparam logic [3:0] S_FINISH = 4'd8;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_WRITE  = 3'd1;
  localparam logic [2:0] OP_WAITVB = 3'd2;
  localparam logic [2:0] OP_DELAY  = 3'd3;
  localparam logic [2:0] OP_END    = 3'd7;

  localparam int CNT_W = 16;
  // Phase counters count down to zero, so each phase loads its length - 1.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [ROM_AW-1:0] ADDR_LAST = '1;

  logic [3:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       a_q;
  logic [7:0]       d_q;
  logic             vblank_prev;
  logic             adv;
  logic             in_bus;

  logic [2:0] op;
  logic [4:0] cmd_reg;
  logic [7:0] cmd_arg;

  assign op      = rom_data[15:13];
  assign cmd_reg = rom_data[12:8];
  assign cmd_arg = rom_data[7:0];

  // adv marks the last cycle of the current command; the step to the next
  // address (or to FINISH when the ROM is exhausted) is shared by all ops.
  always_comb begin
    adv = 1'b0;
    case (state)
      S_DECODE: adv = (op == OP_NOP);
      S_HOLD:   adv = (cnt == '0);
      S_WAITVB: adv = vblank && !vblank_prev;
      S_DELAY:  adv = (cnt == '0);
      default:  adv = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rom_addr    <= '0;
      cnt         <= '0;
      a_q         <= '0;
      d_q         <= '0;
      vblank_prev <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      vblank_prev <= vblank;
      if (adv) begin
        if (rom_addr == ADDR_LAST) begin
          // No END before the last word: abort without wrapping the address.
          state <= S_FINISH;
          error <= 1'b1;
        end else begin
          rom_addr <= rom_addr + ROM_AW'(1);
          state    <= S_FETCH;
        end
      end else begin
        case (state)
          S_IDLE, S_FINISH: begin
            if (start) begin
              rom_addr <= '0;
              done     <= 1'b0;
              error    <= 1'b0;
              state    <= S_FETCH;
            end
          end
          S_FETCH: state <= S_DECODE;
          S_DECODE: begin
            case (op)
              OP_NOP: ;
              OP_WRITE: begin
                a_q   <= cmd_reg;
                d_q   <= cmd_arg;
                cnt   <= SETUP_LD;
                state <= S_SETUP;
              end
              OP_WAITVB: state <= S_WAITVB;
              OP_DELAY: begin
                cnt   <= CNT_W'(cmd_arg);
                state <= S_DELAY;
              end
              OP_END: begin
                done  <= 1'b1;
                state <= S_FINISH;
              end
              default: begin
                error <= 1'b1;
                state <= S_FINISH;
              end
            endcase
          end
          S_SETUP: begin
            if (cnt == '0) begin
              cnt   <= STROBE_LD;
              state <= S_STROBE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_STROBE: begin
            if (cnt == '0) begin
              cnt   <= HOLD_LD;
              state <= S_HOLD;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_HOLD, S_DELAY: cnt <= cnt - CNT_W'(1);
          S_WAITVB: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Bus strobes decode straight from state so reset releases them at once,
  // even in the middle of a strobe.
  assign in_bus       = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
  assign extbus.cs_n  = ~in_bus;
  assign extbus.wr_n  = (state != S_STROBE);
  assign extbus.rd_n  = 1'b1;
  assign extbus.d_oe  = in_bus;
  assign extbus.a     = a_q;
  assign extbus.d_out = d_q;

  assign busy = (state != S_IDLE) && (state != S_FINISH);

endmodule
